// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_IDLE_TIMEOUT = 20000;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request strictly after ptr_i, wrapping.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  logic [IDX_W-1:0] cand;
  logic             hit;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    cand     = '0;
    hit      = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(ptr_i) + i) % N);
      if (!hit && req_i[cand]) begin
        hit            = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte channel; a silent owner is evicted by timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = UART_DATA_W,
  parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
  parameter int ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_last_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [ID_W-1:0]         grant_id_o,
  output logic                    busy_o,
  output logic                    timeout_o
);

  localparam int              CNT_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ID_W-1:0]   last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic [N_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;

  logic [DATA_W-1:0] data_masked [N_REQ];
  logic [DATA_W-1:0] owner_data;
  logic              owner_valid;
  logic              owner_last;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (last_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .found_o  (pick_found)
  );

  // grant_q is all-zero in IDLE, so the AND-OR mux yields zero data there.
  genvar gi;
  for (gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign data_masked[gi] = grant_q[gi] ? req_data_i[gi*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    owner_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      owner_data = owner_data | data_masked[k];
    end
  end

  assign owner_valid = |(req_valid_i & grant_q);
  assign owner_last  = |(req_last_i & grant_q);

  assign tx_valid_o  = owner_valid;
  assign tx_data_o   = owner_data;
  assign req_ready_o = grant_q & {N_REQ{tx_ready_i}};
  assign grant_o     = grant_q;
  assign grant_id_o  = grant_id_q;
  assign busy_o      = (state_q == ARB_OWN);
  assign timeout_o   = timeout_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_ptr_d = last_ptr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          state_d    = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (owner_valid) begin
          cnt_d = '0;
          if (tx_ready_i && owner_last) begin
            last_ptr_d = grant_id_q;
            grant_d    = '0;
            grant_id_d = '0;
            state_d    = ARB_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Only owner silence counts; backpressure never revokes the grant.
          timeout_d  = 1'b1;
          last_ptr_d = grant_id_q;
          grant_d    = '0;
          grant_id_d = '0;
          cnt_d      = '0;
          state_d    = ARB_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_ptr_q <= ID_W'(N_REQ - 1);
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_ptr_q <= last_ptr_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule
